// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave frame receiver: FSM states,
// parameter limits and the CPOL/CPHA edge-select rule.
package spi_pkg;

  localparam int MAX_WORD_W  = 32;
  localparam int MAX_N_WORDS = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } spi_state_e;

  // Data is sampled on the rising SCK edge when CPOL and CPHA agree,
  // otherwise on the falling edge; the shift edge is always the other one.
  function automatic bit sample_on_rise(input int cpol, input int cpha);
    return (cpol != 0) == (cpha != 0);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Brings the asynchronous SPI pins into the clk domain and derives
// single-cycle edge pulses from the synchronised levels.
module spi_pin_sync (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic ss_n,
  input  logic mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic ss_s,
  output logic ss_fall,
  output logic ss_rise,
  output logic mosi_s
);

  logic [1:0] sck_ff, ss_ff, mosi_ff;
  logic       sck_d, ss_d;

  // 2-FF synchronisers plus one delayed copy for edge detection. The select
  // chain resets low so a select held low across reset never produces a fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_ff  <= '0;
      ss_ff   <= '0;
      mosi_ff <= '0;
      sck_d   <= 1'b0;
      ss_d    <= 1'b0;
    end else begin
      sck_ff  <= {sck_ff[0], sck};
      ss_ff   <= {ss_ff[0], ss_n};
      mosi_ff <= {mosi_ff[0], mosi};
      sck_d   <= sck_ff[1];
      ss_d    <= ss_ff[1];
    end
  end

  assign ss_s     = ss_ff[1];
  assign mosi_s   = mosi_ff[1];
  assign sck_rise =  sck_ff[1] & ~sck_d;
  assign sck_fall = ~sck_ff[1] &  sck_d;
  assign ss_fall  = ~ss_ff[1]  &  ss_d;
  assign ss_rise  =  ss_ff[1]  & ~ss_d;

endmodule

// File: rtl/spi_slave_frame_rx.sv
// SPI slave that assembles fixed-length frames of N_WORDS x WORD_W bits,
// hands them over through a valid/ack register bank and returns a status
// word on MISO. Everything runs on clk; SCK is only observed as a level.
module spi_slave_frame_rx
  import spi_pkg::*;
#(
  parameter int WORD_W    = 16,
  parameter int N_WORDS   = 4,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int MSB_FIRST = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sck,
  input  logic                      ss_n,
  input  logic                      mosi,
  output logic                      miso,
  output logic                      miso_oe,
  input  logic [WORD_W-1:0]         tx_word,
  output logic [N_WORDS*WORD_W-1:0] frame_data,
  output logic                      frame_valid,
  input  logic                      frame_ack,
  output logic                      frame_err,
  output logic                      overrun
);

  localparam bit              SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
  localparam int              BCW         = $clog2(MAX_WORD_W);
  localparam int              WCW         = $clog2(MAX_N_WORDS);
  localparam logic [BCW-1:0]  LAST_BIT    = BCW'(WORD_W - 1);
  localparam logic [WCW-1:0]  LAST_WORD   = WCW'(N_WORDS - 1);

  logic sck_rise, sck_fall, ss_s, ss_fall, ss_rise, mosi_s;

  spi_pin_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .sck      (sck),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .ss_s     (ss_s),
    .ss_fall  (ss_fall),
    .ss_rise  (ss_rise),
    .mosi_s   (mosi_s)
  );

  spi_state_e state, state_nxt;
  logic [BCW-1:0]  bit_cnt;
  logic [WCW-1:0]  word_cnt;
  logic [WORD_W-1:0] rx_sr, tx_sr, rx_word;
  logic [N_WORDS-1:0][WORD_W-1:0] wbuf, frame_q, frame_nxt;
  logic armed, skip_shift;
  logic sample_ev, shift_ev, last_bit, last_word;
  logic start, abort, frame_done;

  assign sample_ev  = SAMPLE_RISE ? sck_rise : sck_fall;
  assign shift_ev   = SAMPLE_RISE ? sck_fall : sck_rise;
  assign last_bit   = (bit_cnt == LAST_BIT);
  assign last_word  = (word_cnt == LAST_WORD);
  assign frame_data = frame_q;

  // Word as it stands once the current MOSI bit is shifted in.
  always_comb begin
    rx_word = (MSB_FIRST != 0) ? {rx_sr[WORD_W-2:0], mosi_s}
                               : {mosi_s, rx_sr[WORD_W-1:1]};
  end

  // Completed frame: stored words plus the word finishing this cycle.
  always_comb begin
    frame_nxt            = wbuf;
    frame_nxt[N_WORDS-1] = rx_word;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state and frame events.
  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    abort      = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ss_fall && armed) begin
          state_nxt = ST_SHIFT;
          start     = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (ss_rise) begin
          state_nxt = ST_IDLE;
          abort     = 1'b1;
        end else if (sample_ev && last_bit && last_word) begin
          state_nxt  = ST_DONE;
          frame_done = 1'b1;
        end
      end
      ST_DONE: begin
        // Trailing bits are ignored until the master releases select.
        if (ss_rise) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Receive/transmit shifters, bit and word counters, word buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      word_cnt   <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      miso       <= 1'b0;
      skip_shift <= 1'b0;
      wbuf       <= '0;
    end else if (start) begin
      bit_cnt    <= '0;
      word_cnt   <= '0;
      // First status bit goes out immediately; with CPHA=1 the first shift
      // edge would otherwise overwrite it before the master samples it.
      miso       <= (MSB_FIRST != 0) ? tx_word[WORD_W-1] : tx_word[0];
      tx_sr      <= (MSB_FIRST != 0) ? (tx_word << 1) : (tx_word >> 1);
      skip_shift <= (CPHA != 0);
    end else if (state == ST_SHIFT && !ss_rise) begin
      if (sample_ev) begin
        rx_sr   <= rx_word;
        bit_cnt <= last_bit ? '0 : bit_cnt + BCW'(1);
        if (last_bit) begin
          for (int k = 0; k < N_WORDS; k++)
            if (word_cnt == WCW'(k)) wbuf[k] <= rx_word;
          word_cnt <= word_cnt + WCW'(1);
        end
      end
      if (shift_ev) begin
        if (skip_shift) begin
          skip_shift <= 1'b0;
        end else begin
          // Zeros fill in behind, so MISO drops to 0 after WORD_W bits.
          miso  <= (MSB_FIRST != 0) ? tx_sr[WORD_W-1] : tx_sr[0];
          tx_sr <= (MSB_FIRST != 0) ? (tx_sr << 1) : (tx_sr >> 1);
        end
      end
    end else if (state_nxt == ST_IDLE) begin
      miso <= 1'b0;
    end
  end

  // Frame hand-over, overrun/abort flags, select tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q     <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      frame_err   <= 1'b0;
      miso_oe     <= 1'b0;
      armed       <= 1'b0;
    end else begin
      frame_err <= abort;
      miso_oe   <= armed & ~ss_s;
      if (ss_s) armed <= 1'b1;
      if (frame_done) begin
        if (!frame_valid || frame_ack) begin
          frame_q     <= frame_nxt;
          frame_valid <= 1'b1;
          overrun     <= 1'b0;
        end else begin
          overrun <= 1'b1;
        end
      end else if (frame_ack && frame_valid) begin
        frame_valid <= 1'b0;
        overrun     <= 1'b0;
      end
    end
  end

endmodule
